// File: rtl/dmem_pkg.sv
// Shared types for the data-memory store buffer: address width and the buffered entry format.
package dmem_pkg;

  localparam int AW         = 32;
  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic [AW-3:0]         addr;  // word index
    logic [31:0]           data;
    logic [WORD_BYTES-1:0] be;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_merge.sv
// Load-forwarding merge: overlays bytes from pending stores onto memory read data,
// youngest matching entry winning per byte lane.
module sb_fwd_merge
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  sb_entry_t     entries [DEPTH],
  input  logic [PW-1:0] rd_ptr,
  input  logic [PW:0]   count,
  input  logic [AW-3:0] waddr,
  input  logic [31:0]   mrdata,
  output logic [31:0]   drdata
);

  logic [PW-1:0] idx;

  // Walk oldest -> youngest so later matches overwrite earlier ones.
  always_comb begin
    drdata = mrdata;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (((PW+1)'(i) < count) && (entries[idx].addr == waddr)) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
          if (entries[idx].be[b]) drdata[8*b +: 8] = entries[idx].data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write buffer between the cpu data port and a dual-port dmem: in-order drain,
// one store per cycle, with byte-wise forwarding to loads.
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] daddr,
  input  logic [31:0]   dwdata,
  input  logic [3:0]    dwe,
  output logic [31:0]   drdata,
  output logic          stall,
  output logic [AW-1:0] mraddr,
  input  logic [31:0]   mrdata,
  output logic [AW-1:0] mwaddr,
  output logic [31:0]   mwdata,
  output logic [3:0]    mwe,
  input  logic          mready,
  output logic          empty
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW-1:0] PTR_ONE  = 1;

  sb_entry_t       entries_q [DEPTH];
  sb_entry_t       entries_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            full, push, pop;
  sb_entry_t       head;
  logic            unused_lsbs;

  // Handshakes: cpu store valid = (dwe != 0), ready = !stall, accepted at the posedge
  // where both hold; memory write valid = (mwe != 0), ready = mready, popped likewise.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign stall = (dwe != 4'h0) && full;
  assign push  = (dwe != 4'h0) && !full;
  assign pop   = !empty && mready;
  assign head  = entries_q[rd_ptr_q];

  assign mraddr = daddr;
  assign mwe    = empty ? 4'h0 : head.be;
  assign mwaddr = empty ? '0 : {head.addr, 2'b00};
  assign mwdata = empty ? '0 : head.data;

  assign unused_lsbs = ^daddr[1:0];

  always_comb begin
    entries_d = entries_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (push) begin
      entries_d[wr_ptr_q] = '{addr: daddr[AW-1:2], data: dwdata, be: dwe};
      wr_ptr_d            = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  sb_fwd_merge #(.DEPTH(DEPTH), .PW(PW)) u_fwd (
    .entries (entries_q),
    .rd_ptr  (rd_ptr_q),
    .count   (count_q),
    .waddr   (daddr[AW-1:2]),
    .mrdata  (mrdata),
    .drdata  (drdata)
  );

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: directed vector table, reset corner sequences and
// randomized traffic checked against a queue-based reference model and a golden memory.
module tb_dmem_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] daddr, dwdata, drdata, mraddr, mrdata, mwaddr, mwdata;
  logic [3:0]  dwe, mwe;
  logic        stall, mready, empty;

  logic [31:0] mem  [256];
  logic [31:0] gmem [256];
  // pending stores, oldest first: {word addr[29:0], data[31:0], be[3:0]}
  logic [65:0] exp_q [$];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic        mready;
    logic        exp_stall;
    logic        exp_empty;
    logic [3:0]  exp_mwe;
    logic [31:0] exp_mwaddr;
    logic [31:0] exp_drdata;
  } vec_t;

  vec_t vecs [17];

  dmem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .daddr  (daddr),
    .dwdata (dwdata),
    .dwe    (dwe),
    .drdata (drdata),
    .stall  (stall),
    .mraddr (mraddr),
    .mrdata (mrdata),
    .mwaddr (mwaddr),
    .mwdata (mwdata),
    .mwe    (mwe),
    .mready (mready),
    .empty  (empty)
  );

  assign mrdata = mem[mraddr[9:2]];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    logic [31:0] r;
    logic [65:0] e;
    r = gmem[a[9:2]];
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      if (e[65:36] == a[31:2]) begin
        for (int b = 0; b < 4; b++) if (e[b]) r[8*b +: 8] = e[4+8*b +: 8];
      end
    end
    return r;
  endfunction

  task automatic check_model(input string tag);
    logic [65:0] h;
    logic        has;
    has = (exp_q.size() > 0);
    h   = has ? exp_q[0] : 66'h0;
    chk({tag, ".stall"},  32'(stall), 32'((dwe != 4'h0) && (exp_q.size() == DEPTH)));
    chk({tag, ".empty"},  32'(empty), 32'(!has));
    chk({tag, ".mwe"},    32'(mwe),   has ? 32'(h[3:0]) : 32'h0);
    chk({tag, ".mwaddr"}, mwaddr,     has ? {h[65:36], 2'b00} : 32'h0);
    chk({tag, ".mwdata"}, mwdata,     has ? h[35:4] : 32'h0);
    chk({tag, ".drdata"}, drdata,     exp_rd(daddr));
    chk({tag, ".mraddr"}, mraddr,     daddr);
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                       input logic rdy);
    daddr  = a;
    dwdata = wd;
    dwe    = we;
    mready = rdy;
    #1;
  endtask

  // One clock: the dmem model absorbs the DUT's write; the reference model pops/pushes.
  task automatic advance();
    logic [3:0]  wbe;
    logic [31:0] wa, wdt;
    logic        rdy, do_pop, do_push;
    logic [65:0] h;
    wbe     = mwe;
    wa      = mwaddr;
    wdt     = mwdata;
    rdy     = mready;
    do_pop  = reset && (exp_q.size() > 0) && mready;
    do_push = reset && (dwe != 4'h0) && (exp_q.size() < DEPTH);
    @(posedge clk);
    if (reset && rdy) begin
      for (int b = 0; b < 4; b++) if (wbe[b]) mem[wa[9:2]][8*b +: 8] = wdt[8*b +: 8];
    end
    if (do_pop) begin
      h = exp_q.pop_front();
      for (int b = 0; b < 4; b++) if (h[b]) gmem[h[43:36]][8*b +: 8] = h[4+8*b +: 8];
    end
    if (do_push) exp_q.push_back({daddr[31:2], dwdata, dwe});
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                              input logic rdy, input logic st, input logic em,
                              input logic [3:0] mw, input logic [31:0] ma,
                              input logic [31:0] rd);
    vec_t v;
    v.daddr = a; v.dwdata = wd; v.dwe = we; v.mready = rdy;
    v.exp_stall = st; v.exp_empty = em; v.exp_mwe = mw; v.exp_mwaddr = ma; v.exp_drdata = rd;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 32'h0;
      gmem[i] = 32'h0;
    end
    mem[8]  = 32'h11223344;
    gmem[8] = 32'h11223344;

    // single store, forwarding, youngest-wins, full/stall with pointer wrap
    vecs[0]  = mk(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b1, 4'h0, 32'h00, 32'h00000000);
    vecs[1]  = mk(32'h10, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 32'h10, 32'hDEADBEEF);
    vecs[2]  = mk(32'h10, 32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h00, 32'hDEADBEEF);
    vecs[3]  = mk(32'h20, 32'h000000AA, 4'h1, 1'b0, 1'b0, 1'b1, 4'h0, 32'h00, 32'h11223344);
    vecs[4]  = mk(32'h20, 32'h0000BB00, 4'h2, 1'b0, 1'b0, 1'b0, 4'h1, 32'h20, 32'h112233AA);
    vecs[5]  = mk(32'h20, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 4'h1, 32'h20, 32'h1122BBAA);
    vecs[6]  = mk(32'h08, 32'h00000001, 4'h1, 1'b0, 1'b0, 1'b0, 4'h1, 32'h20, 32'h00000000);
    vecs[7]  = mk(32'h08, 32'h00000002, 4'h1, 1'b0, 1'b0, 1'b0, 4'h1, 32'h20, 32'h00000001);
    vecs[8]  = mk(32'h08, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 4'h1, 32'h20, 32'h00000002);
    vecs[9]  = mk(32'h30, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1, 1'b0, 4'h1, 32'h20, 32'h00000000);
    vecs[10] = mk(32'h30, 32'hCAFEF00D, 4'hF, 1'b1, 1'b1, 1'b0, 4'h1, 32'h20, 32'h00000000);
    vecs[11] = mk(32'h30, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 1'b0, 4'h2, 32'h20, 32'h00000000);
    vecs[12] = mk(32'h20, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 4'h2, 32'h20, 32'h1122BBAA);
    vecs[13] = mk(32'h08, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 4'h1, 32'h08, 32'h00000002);
    vecs[14] = mk(32'h08, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 4'h1, 32'h08, 32'h00000002);
    vecs[15] = mk(32'h30, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 32'h30, 32'hCAFEF00D);
    vecs[16] = mk(32'h30, 32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h00, 32'hCAFEF00D);

    // reset held with a store request: nothing accepted, nothing written
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      apply(32'h40, 32'hFFFFFFFF, 4'hF, 1'b1);
      chk("rst.empty", 32'(empty), 32'h1);
      chk("rst.mwe",   32'(mwe),   32'h0);
      chk("rst.stall", 32'(stall), 32'h0);
      check_model("rst");
      advance();
    end
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      apply(32'h40, 32'h0, 4'h0, 1'b1);
      check_model("post_rst");
      advance();
    end

    // directed table
    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].daddr, vecs[i].dwdata, vecs[i].dwe, vecs[i].mready);
      chk($sformatf("vec%0d.stall", i),  32'(stall), 32'(vecs[i].exp_stall));
      chk($sformatf("vec%0d.empty", i),  32'(empty), 32'(vecs[i].exp_empty));
      chk($sformatf("vec%0d.mwe", i),    32'(mwe),   32'(vecs[i].exp_mwe));
      chk($sformatf("vec%0d.mwaddr", i), mwaddr,     vecs[i].exp_mwaddr);
      chk($sformatf("vec%0d.drdata", i), drdata,     vecs[i].exp_drdata);
      check_model($sformatf("vec%0d", i));
      advance();
    end
    chk("t2.mem4", mem[4], 32'hDEADBEEF);
    chk("t4.mem2", mem[2], 32'h00000002);

    // reset mid-operation with three pending stores
    apply(32'h44, 32'h11111111, 4'hF, 1'b0); advance();
    apply(32'h48, 32'h22222222, 4'hF, 1'b0); advance();
    apply(32'h4C, 32'h33333333, 4'hF, 1'b0); advance();
    apply(32'h44, 32'h0, 4'h0, 1'b0);
    check_model("pre_midrst");
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst.empty",  32'(empty), 32'h1);
    chk("midrst.mwe",    32'(mwe),   32'h0);
    chk("midrst.mwaddr", mwaddr,     32'h0);
    chk("midrst.drdata", drdata,     gmem[17]);
    apply(32'h44, 32'hFFFFFFFF, 4'hF, 1'b1);
    check_model("midrst_hold");
    advance();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      apply(32'h44, 32'h0, 4'h0, 1'b1);
      check_model("after_midrst");
      advance();
    end
    chk("midrst.mem17", mem[17], 32'h0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      apply({26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
            $urandom,
            ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
            ($urandom_range(0, 3) != 0));
      check_model("rand");
      advance();
    end
    for (int c = 0; c < DEPTH + 2; c++) begin
      apply(32'h0, 32'h0, 4'h0, 1'b1);
      check_model("drain");
      advance();
    end
    chk("final.empty", 32'(empty), 32'h1);
    for (int w = 0; w < 32; w++) chk($sformatf("final.mem%0d", w), mem[w], gmem[w]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
